// File: rtl/pga_autorange_pkg.sv
// Shared definitions for the PGA autorange controller: gain limits, clip level, state encoding.
package pga_autorange_pkg;

    localparam int unsigned GAIN_W       = 2;
    localparam int unsigned SAMPLE_W     = 16;
    localparam int unsigned MAG_W        = 15;
    localparam int unsigned CLIP_LIM_DEF = 30720;

    localparam logic [GAIN_W-1:0] GAIN_MIN = 2'd0;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 2'd3;

    typedef enum logic {
        ST_SETTLE  = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Saturating magnitude: -32768 maps to 32767 so the result always fits MAG_W bits.
    function automatic logic [MAG_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] neg;
        neg = SAMPLE_W'(~s + SAMPLE_W'(1));
        if (!s[SAMPLE_W-1])
            return s[MAG_W-1:0];
        else if (s == {1'b1, {(SAMPLE_W-1){1'b0}}})
            return {MAG_W{1'b1}};
        else
            return neg[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/pga_autorange_abs_peak.sv
// Saturating |sample|, running peak register with clear, and combinational peak'/clip for the FSM.
module pga_autorange_abs_peak
    import pga_autorange_pkg::*;
#(
    parameter int unsigned CLIP_LIM = CLIP_LIM_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                vld,
    input  logic                clr,
    output logic [MAG_W-1:0]    peak_next_c,
    output logic                clip_c
);

    logic [MAG_W-1:0] mag_c;
    logic [MAG_W-1:0] peak;

    always_comb begin
        mag_c       = sat_abs(sample);
        peak_next_c = (mag_c > peak) ? mag_c : peak;
        clip_c      = {{(32-MAG_W){1'b0}}, mag_c} >= CLIP_LIM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            peak <= '0;
        else if (clr)
            peak <= '0;
        else if (vld)
            peak <= peak_next_c;
    end

endmodule

// File: rtl/pga_autorange.sv
// PGA autorange controller: fast step-down on clipping, slow step-up after a quiet window,
// blanking while the PGA settles, manual gain pass-through when auto mode is off.
module pga_autorange
    import pga_autorange_pkg::*;
#(
    parameter int unsigned WINDOW    = 4096,
    parameter int unsigned SETTLE    = 256,
    parameter int unsigned CLIP_LIM  = CLIP_LIM_DEF,
    parameter int unsigned LO_THRESH = 7168
) (
    input  logic                CLK36,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_vld,
    input  logic                auto_en,
    input  logic [GAIN_W-1:0]   manual_gain,
    output logic [GAIN_W-1:0]   gain,
    output logic                gain_chg,
    output logic                settling,
    output logic                overload
);

    localparam int unsigned WIN_W = $clog2(WINDOW);
    localparam int unsigned SET_W = $clog2(SETTLE);
    localparam int unsigned CNT_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             auto_q;

    logic [MAG_W-1:0] peak_next_c;
    logic             clip_c;
    logic             win_end_c;
    logic             settle_end_c;
    logic             peak_clr_c;
    logic             quiet_c;
    logic             below_clip_c;

    always_comb begin
        win_end_c    = cnt == CNT_W'(WINDOW - 1);
        settle_end_c = cnt == CNT_W'(SETTLE - 1);
        quiet_c      = {{(32-MAG_W){1'b0}}, peak_next_c} < LO_THRESH;
        below_clip_c = {{(32-MAG_W){1'b0}}, peak_next_c} < CLIP_LIM;
        peak_clr_c   = (state == ST_SETTLE) || !auto_en || (sample_vld && win_end_c);
    end

    pga_autorange_abs_peak #(
        .CLIP_LIM (CLIP_LIM)
    ) u_abs_peak (
        .clk         (CLK36),
        .rst         (rst),
        .sample      (sample),
        .vld         (sample_vld),
        .clr         (peak_clr_c),
        .peak_next_c (peak_next_c),
        .clip_c      (clip_c)
    );

    always_ff @(posedge CLK36 or posedge rst) begin
        if (rst) begin
            state    <= ST_SETTLE;
            gain     <= GAIN_MIN;
            gain_chg <= 1'b0;
            settling <= 1'b1;
            overload <= 1'b0;
            cnt      <= '0;
            auto_q   <= 1'b1;
        end else begin
            gain_chg <= 1'b0;
            auto_q   <= auto_en;
            if (!auto_en) begin
                // Manual mode: follow the UI, still blank after each change.
                overload <= 1'b0;
                gain     <= manual_gain;
                if (manual_gain != gain) begin
                    gain_chg <= 1'b1;
                    state    <= ST_SETTLE;
                    settling <= 1'b1;
                    cnt      <= '0;
                end else if (sample_vld && state == ST_SETTLE) begin
                    if (settle_end_c) begin
                        state    <= ST_MEASURE;
                        settling <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end else if (!auto_q) begin
                state    <= ST_SETTLE;
                settling <= 1'b1;
                cnt      <= '0;
            end else if (sample_vld) begin
                case (state)
                    ST_SETTLE: begin
                        if (settle_end_c) begin
                            state    <= ST_MEASURE;
                            settling <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        // Clip beats the window-end decision, even on the last sample.
                        if (clip_c && gain != GAIN_MIN) begin
                            gain     <= gain - GAIN_W'(1);
                            gain_chg <= 1'b1;
                            state    <= ST_SETTLE;
                            settling <= 1'b1;
                            cnt      <= '0;
                        end else begin
                            if (clip_c)
                                overload <= 1'b1;
                            if (win_end_c) begin
                                cnt <= '0;
                                if (below_clip_c)
                                    overload <= 1'b0;
                                if (quiet_c && gain != GAIN_MAX) begin
                                    gain     <= gain + GAIN_W'(1);
                                    gain_chg <= 1'b1;
                                    state    <= ST_SETTLE;
                                    settling <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= ST_SETTLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pga_autorange.sv
// Directed bench for pga_autorange with WINDOW=16, SETTLE=4 and default thresholds.
module tb_pga_autorange;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample = '0;
    logic        vld = 1'b0;
    logic        auto_en = 1'b1;
    logic [1:0]  manual_gain = 2'd0;
    logic [1:0]  gain;
    logic        gain_chg;
    logic        settling;
    logic        overload;

    int n_checks = 0;
    int n_errors = 0;
    int n_chg    = 0;

    always #5 clk = ~clk;

    pga_autorange #(
        .WINDOW (16),
        .SETTLE (4)
    ) dut (
        .CLK36       (clk),
        .rst         (rst),
        .sample      (sample),
        .sample_vld  (vld),
        .auto_en     (auto_en),
        .manual_gain (manual_gain),
        .gain        (gain),
        .gain_chg    (gain_chg),
        .settling    (settling),
        .overload    (overload)
    );

    // Count gain_chg pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && gain_chg)
            n_chg++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive n back-to-back valid samples starting at a falling edge; returns at a falling edge.
    task automatic send(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            sample = 16'(s);
            vld    = 1'b1;
            @(negedge clk);
        end
        vld = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_gain", int'(gain), 0);
        check("rst_chg", int'(gain_chg), 0);
        check("rst_settling", int'(settling), 1);
        check("rst_overload", int'(overload), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        send(0, 3);
        check("settle_3", int'(settling), 1);
        send(0, 1);
        check("settle_4", int'(settling), 0);
        check("settle_gain", int'(gain), 0);
        check("settle_ovl", int'(overload), 0);

        for (int g = 1; g <= 3; g++) begin
            send(1000, 15);
            check("quiet_pre_end", int'(gain), g - 1);
            send(-1000, 1);
            check("quiet_step_gain", int'(gain), g);
            check("quiet_step_chg", int'(gain_chg), 1);
            check("quiet_step_settling", int'(settling), 1);
            send(1000, 4);
            check("quiet_resettle", int'(settling), 0);
        end
        send(1000, 16);
        check("top_hold_gain", int'(gain), 3);
        check("top_hold_chg", int'(gain_chg), 0);

        send(1000, 15);
        send(31000, 1);
        check("last_clip_gain", int'(gain), 2);
        check("last_clip_chg", int'(gain_chg), 1);

        send(0, 4);
        send(-32768, 1);
        check("neg_full_gain", int'(gain), 1);
        check("neg_full_chg", int'(gain_chg), 1);
        check("neg_full_settling", int'(settling), 1);

        send(0, 4);
        send(31000, 1);
        check("clip_g1_gain", int'(gain), 0);

        send(0, 4);
        send(31000, 1);
        check("ovl_gain", int'(gain), 0);
        check("ovl_set", int'(overload), 1);
        check("ovl_chg", int'(gain_chg), 0);
        check("ovl_settling", int'(settling), 0);
        send(2000, 15);
        check("ovl_win_end_hold", int'(overload), 1);
        check("ovl_win_end_gain", int'(gain), 0);
        send(2000, 16);
        check("ovl_clear", int'(overload), 0);
        check("ovl_clear_gain", int'(gain), 1);
        check("ovl_clear_chg", int'(gain_chg), 1);

        send(0, 4);
        send(7168, 16);
        check("lo_thresh_hold", int'(gain), 1);
        check("lo_thresh_chg", int'(gain_chg), 0);

        @(negedge clk);
        check("auto_chg_count", n_chg, 7);

        auto_en     = 1'b0;
        manual_gain = 2'd2;
        @(negedge clk);
        check("manual_gain", int'(gain), 2);
        check("manual_chg", int'(gain_chg), 1);
        check("manual_settling", int'(settling), 1);
        check("manual_overload", int'(overload), 0);
        @(negedge clk);
        check("manual_chg_once", int'(gain_chg), 0);
        check("total_chg_count", n_chg, 8);

        send(0, 2);
        check("manual_mid_settle", int'(settling), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gain", int'(gain), 0);
        check("async_rst_settling", int'(settling), 1);
        check("async_rst_chg", int'(gain_chg), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
